// File: rtl/pi_pixel_renderer.sv
// pi_pixel_renderer: tracks the VGA pixel coordinate and draws the Monte Carlo pi plot with the last four sample markers.
module pi_pixel_renderer #(
  parameter int PLOT_X0   = 80,
  parameter int RADIUS_SQ = 230400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixEn,
  input  logic        hsIn,
  input  logic        vsIn,
  input  logic        vidIn,
  input  logic        ptValid,
  input  logic [8:0]  ptX,
  input  logic [8:0]  ptY,
  output logic [11:0] rgb,
  output logic        hsOut,
  output logic        vsOut,
  output logic [15:0] frameCount
);
  localparam logic [9:0]  X0 = 10'(PLOT_X0);
  localparam logic [9:0]  X1 = 10'(PLOT_X0 + 480);
  localparam logic [18:0] R2 = 19'(RADIUS_SQ);
  logic prev_vid, prev_vs, vid_rise, vid_fall, vs_rise, in_plot_n, pt_ok, pt_in;
  logic [9:0] x, y, x_n, y_n;
  logic [17:0] px2, py2;
  logic [1:0] wr_ptr;
  logic [3:0][8:0] sh_x, sh_y, ds_x, ds_y;
  logic [3:0] sh_in, sh_v, ds_in, ds_v, hit;
  logic s1_vid, s1_hs, s1_vs, s1_plot;
  logic [8:0] s1_u, s1_v;
  logic s2_vid, s2_hs, s2_vs, s2_plot, s2_hit, s2_hin;
  logic [17:0] s2_uu, s2_vv;
  assign vid_rise = vidIn & ~prev_vid;
  assign vid_fall = ~vidIn & prev_vid;
  assign vs_rise  = vsIn & ~prev_vs;
  // S1 samples the coordinate this strobe produces, so the first active pixel is x=0
  always_comb begin
    x_n = vid_rise ? 10'd0 : (vidIn && x != 10'h3FF) ? x + 10'd1 : x;
    y_n = vs_rise ? 10'd0 : (vid_fall && y != 10'h3FF) ? y + 10'd1 : y;
    in_plot_n = x_n >= X0 && x_n < X1 && y_n < 10'd480;
  end
  assign px2   = {9'd0, ptX} * {9'd0, ptX};
  assign py2   = {9'd0, ptY} * {9'd0, ptY};
  assign pt_in = {1'b0, px2} + {1'b0, py2} < R2;
  assign pt_ok = ptValid && ptX < 9'd480 && ptY < 9'd480;
  // Markers are clipped to the plot square, so hits are gated by in-plot
  always_comb
    for (int i = 0; i < 4; i++)
      hit[i] = ds_v[i] & s1_plot
             & ({1'b0, s1_u} + 10'd1 >= {1'b0, ds_x[i]}) & ({1'b0, ds_x[i]} + 10'd1 >= {1'b0, s1_u})
             & ({1'b0, s1_v} + 10'd1 >= {1'b0, ds_y[i]}) & ({1'b0, ds_y[i]} + 10'd1 >= {1'b0, s1_v});
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      sh_x <= '0;
      sh_y <= '0;
      sh_in <= '0;
      sh_v <= '0;
    end else if (pt_ok) begin
      sh_x[wr_ptr] <= ptX;
      sh_y[wr_ptr] <= ptY;
      sh_in[wr_ptr] <= pt_in;
      sh_v[wr_ptr] <= 1'b1;
      wr_ptr <= wr_ptr + 2'd1;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {prev_vid, prev_vs, x, y, frameCount} <= '0;
      {ds_x, ds_y, ds_in, ds_v} <= '0;
      {s1_vid, s1_hs, s1_vs, s1_plot, s1_u, s1_v} <= '0;
      {s2_vid, s2_hs, s2_vs, s2_plot, s2_hit, s2_hin, s2_uu, s2_vv} <= '0;
      {rgb, hsOut, vsOut} <= '0;
    end else if (pixEn) begin
      prev_vid <= vidIn;
      prev_vs <= vsIn;
      x <= x_n;
      y <= y_n;
      if (vs_rise) begin
        frameCount <= frameCount + 16'd1;
        ds_x <= sh_x;
        ds_y <= sh_y;
        ds_in <= sh_in;
        ds_v <= sh_v;
      end
      s1_vid <= vidIn;
      s1_hs <= hsIn;
      s1_vs <= vsIn;
      s1_plot <= in_plot_n;
      s1_u <= 9'(x_n - X0);
      s1_v <= 9'(10'd479 - y_n);
      s2_vid <= s1_vid;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
      s2_plot <= s1_plot;
      s2_hit <= |hit;
      s2_hin <= hit[0] ? ds_in[0] : hit[1] ? ds_in[1] : hit[2] ? ds_in[2] : ds_in[3];
      s2_uu <= {9'd0, s1_u} * {9'd0, s1_u};
      s2_vv <= {9'd0, s1_v} * {9'd0, s1_v};
      rgb <= !s2_vid ? 12'h000 : s2_hit ? (s2_hin ? 12'hF00 : 12'h0F0) : !s2_plot ? 12'h444
           : ({1'b0, s2_uu} + {1'b0, s2_vv} < R2) ? 12'h00F : 12'h000;
      hsOut <= s2_hs;
      vsOut <= s2_vs;
    end
endmodule

// File: tb/tb_pi_pixel_renderer.sv
// tb_pi_pixel_renderer: frame-level checks of pi_pixel_renderer against a pixel-rule reference model.
module tb_pi_pixel_renderer;
  logic clk = 0, reset = 0, pixEn = 0, hsIn = 0, vsIn = 0, vidIn = 0, ptValid = 0;
  logic [8:0] ptX = 0, ptY = 0;
  logic [11:0] rgb;
  logic hsOut, vsOut;
  logic [15:0] frameCount;

  pi_pixel_renderer dut (.clk(clk), .reset(reset), .pixEn(pixEn), .hsIn(hsIn), .vsIn(vsIn), .vidIn(vidIn),
                         .ptValid(ptValid), .ptX(ptX), .ptY(ptY), .rgb(rgb), .hsOut(hsOut), .vsOut(vsOut),
                         .frameCount(frameCount));

  always #5 clk = ~clk;

  typedef struct {int x; int y; int s;} pt_t;
  typedef struct {logic [13:0] w; logic vid; int key;} ent_t;
  typedef struct {int line; int x; int y;} pend_t;

  pt_t acc[$], disp[$];
  ent_t hist[$];
  pend_t pend[$];
  logic [13:0] expq[$], obsq[$];
  logic [11:0] seen[int];
  int longs[$];
  int n_cmp = 0, n_bad = 0, nacc = 0, fc_m = 0, gap = 0;
  logic last_vs = 0, co_v = 0;
  int co_x = 0, co_y = 0;

  function automatic int iabs(int a);
    return a < 0 ? -a : a;
  endfunction

  function automatic logic in_circle(int a, int b);
    return a * a + b * b < 230400;
  endfunction

  // Expected colour of an active pixel from the plot rules, using the latched marker set
  function automatic logic [11:0] colour(int x, int y);
    int u, v, best;
    logic hin;
    u = x - 80; v = 479 - y; best = 4; hin = 0;
    if (x < 80 || x >= 560 || y >= 480) return 12'h444;
    foreach (disp[i])
      if (iabs(u - disp[i].x) <= 1 && iabs(v - disp[i].y) <= 1 && disp[i].s < best) begin
        best = disp[i].s;
        hin = in_circle(disp[i].x, disp[i].y);
      end
    if (best < 4) return hin ? 12'hF00 : 12'h0F0;
    return in_circle(u, v) ? 12'h00F : 12'h000;
  endfunction

  // Accepted points land in slot (count mod 4); only the newest four survive
  function automatic void add_pt(int x, int y);
    if (x < 480 && y < 480) begin
      acc.push_back('{x, y, nacc % 4});
      nacc++;
      if (acc.size() > 4) void'(acc.pop_front());
    end
  endfunction

  function automatic logic is_long(int y);
    foreach (longs[i]) if (longs[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic hw_reset();
    reset = 0; hsIn = 0; vsIn = 0; vidIn = 0; pixEn = 0; ptValid = 0;
    acc.delete(); disp.delete(); hist.delete(); expq.delete(); obsq.delete();
    nacc = 0; fc_m = 0; last_vs = 0;
    hist.push_back('{14'd0, 1'b0, 0});
    hist.push_back('{14'd0, 1'b0, 0});
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic pix(input logic h, input logic v, input logic d, input int x, input int y);
    ent_t e;
    hsIn = h; vsIn = v; vidIn = d; pixEn = 1;
    ptValid = co_v; ptX = 9'(co_x); ptY = 9'(co_y);
    if (v && !last_vs) begin
      disp = acc;
      fc_m++;
    end
    if (co_v) add_pt(co_x, co_y);
    co_v = 0; last_vs = v;
    e.w = {d ? colour(x, y) : 12'h000, h, v};
    e.vid = d;
    e.key = y * 1024 + x;
    hist.push_back(e);
    @(posedge clk); #1;
    e = hist.pop_front();
    expq.push_back(e.w);
    obsq.push_back({rgb, hsOut, vsOut});
    if (e.vid) seen[e.key] = rgb;
    pixEn = 0; ptValid = 0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic put_pt(input int x, input int y);
    ptValid = 1; ptX = 9'(x); ptY = 9'(y); pixEn = 0;
    add_pt(x, y);
    @(posedge clk); #1;
    ptValid = 0;
  endtask

  task automatic frame();
    int len;
    seen.delete();
    pix(0, 0, 0, 0, 0);
    foreach (pend[i]) if (pend[i].line < 0) begin co_v = 1; co_x = pend[i].x; co_y = pend[i].y; end
    pix(0, 1, 0, 0, 0);
    pix(0, 1, 0, 0, 0);
    pix(0, 0, 0, 0, 0);
    for (int y = 0; y < 480; y++) begin
      foreach (pend[i]) if (pend[i].line == y) put_pt(pend[i].x, pend[i].y);
      len = is_long(y) ? 640 : 2;
      for (int x = 0; x < len; x++) pix(0, 0, 1, x, y);
      pix(0, 0, 0, 0, 0);
      pix(1, 0, 0, 0, 0);
      pix(0, 0, 0, 0, 0);
    end
    pend.delete();
    longs.delete();
  endtask

  task automatic test_reset();
    logic [13:0] w_e, w_o;
    hw_reset();
    n_cmp++; if ({rgb, hsOut, vsOut} !== 14'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", {rgb, hsOut, vsOut}); end
    n_cmp++; if (frameCount !== 16'd0) begin n_bad++; $display("FAIL reset_frame_count: got %0d want 0", frameCount); end
    pix(1, 1, 0, 0, 0);
    n_cmp++; if ({hsOut, vsOut} !== 2'b00) begin n_bad++; $display("FAIL sync_strobe1: got %b want 00", {hsOut, vsOut}); end
    n_cmp++; if (frameCount !== 16'd1) begin n_bad++; $display("FAIL first_vs_count: got %0d want 1", frameCount); end
    pix(1, 1, 0, 0, 0);
    n_cmp++; if ({hsOut, vsOut} !== 2'b00) begin n_bad++; $display("FAIL sync_strobe2: got %b want 00", {hsOut, vsOut}); end
    pix(1, 1, 0, 0, 0);
    n_cmp++; if ({hsOut, vsOut} !== 2'b11) begin n_bad++; $display("FAIL sync_strobe3: got %b want 11", {hsOut, vsOut}); end
    pix(0, 0, 0, 0, 0);
    pix(0, 0, 0, 0, 0);
    while (expq.size() > 0) begin
      w_e = expq.pop_front(); w_o = obsq.pop_front(); n_cmp++;
      if (w_o !== w_e) begin n_bad++; $display("FAIL stream_reset: rgb/hs/vs got %h want %h", w_o, w_e); end
    end
  endtask

  task automatic test_plain_frame();
    logic [13:0] w_e, w_o;
    longs = '{0, 100, 479};
    frame();
    n_cmp++; if (seen[479 * 1024 + 80] !== 12'h00F) begin n_bad++; $display("FAIL origin_pixel: got %h want 00F", seen[479 * 1024 + 80]); end
    n_cmp++; if (seen[559] !== 12'h000) begin n_bad++; $display("FAIL far_corner: got %h want 000", seen[559]); end
    n_cmp++; if (seen[100 * 1024] !== 12'h444) begin n_bad++; $display("FAIL border_pixel: got %h want 444", seen[100 * 1024]); end
    n_cmp++; if (frameCount !== 16'(fc_m)) begin n_bad++; $display("FAIL frame_count_plain: got %0d want %0d", frameCount, fc_m); end
    while (expq.size() > 0) begin
      w_e = expq.pop_front(); w_o = obsq.pop_front(); n_cmp++;
      if (w_o !== w_e) begin n_bad++; $display("FAIL stream_plain: rgb/hs/vs got %h want %h", w_o, w_e); end
    end
  endtask

  task automatic test_point_next_frame();
    logic [13:0] w_e, w_o;
    pend.push_back('{200, 10, 10});
    longs = '{468, 469, 470};
    frame();
    n_cmp++; if (seen[469 * 1024 + 90] !== 12'h00F) begin n_bad++; $display("FAIL point_not_yet: got %h want 00F", seen[469 * 1024 + 90]); end
    longs = '{468, 469, 470};
    frame();
    for (int v = 9; v <= 11; v++)
      for (int u = 9; u <= 11; u++) begin
        n_cmp++;
        if (seen[(479 - v) * 1024 + 80 + u] !== 12'hF00) begin
          n_bad++; $display("FAIL marker_u%0d_v%0d: got %h want F00", u, v, seen[(479 - v) * 1024 + 80 + u]);
        end
      end
    n_cmp++; if (seen[469 * 1024 + 92] !== 12'h00F) begin n_bad++; $display("FAIL marker_edge: got %h want 00F", seen[469 * 1024 + 92]); end
    while (expq.size() > 0) begin
      w_e = expq.pop_front(); w_o = obsq.pop_front(); n_cmp++;
      if (w_o !== w_e) begin n_bad++; $display("FAIL stream_point: rgb/hs/vs got %h want %h", w_o, w_e); end
    end
  endtask

  task automatic test_corner_and_drop();
    logic [13:0] w_e, w_o;
    put_pt(479, 479);
    put_pt(480, 0);
    longs = '{0, 1, 2};
    frame();
    for (int y = 0; y <= 1; y++)
      for (int x = 558; x <= 559; x++) begin
        n_cmp++;
        if (seen[y * 1024 + x] !== 12'h0F0) begin n_bad++; $display("FAIL corner_x%0d_y%0d: got %h want 0F0", x, y, seen[y * 1024 + x]); end
      end
    n_cmp++; if (seen[560] !== 12'h444) begin n_bad++; $display("FAIL corner_clip: got %h want 444", seen[560]); end
    n_cmp++; if (seen[2 * 1024 + 559] !== 12'h000) begin n_bad++; $display("FAIL corner_below: got %h want 000", seen[2 * 1024 + 559]); end
    while (expq.size() > 0) begin
      w_e = expq.pop_front(); w_o = obsq.pop_front(); n_cmp++;
      if (w_o !== w_e) begin n_bad++; $display("FAIL stream_corner: rgb/hs/vs got %h want %h", w_o, w_e); end
    end
  endtask

  task automatic test_five_points();
    logic [13:0] w_e, w_o;
    hw_reset();
    put_pt(0, 0);
    put_pt(340, 340);
    put_pt(339, 339);
    put_pt(0, 479);
    put_pt(341, 341);
    longs = '{0, 137, 138, 139, 140, 141, 479};
    frame();
    n_cmp++; if (seen[139 * 1024 + 420] !== 12'h0F0) begin n_bad++; $display("FAIL overlap_slot0: got %h want 0F0", seen[139 * 1024 + 420]); end
    n_cmp++; if (seen[140 * 1024 + 419] !== 12'h0F0) begin n_bad++; $display("FAIL overlap_slot1: got %h want 0F0", seen[140 * 1024 + 419]); end
    n_cmp++; if (seen[141 * 1024 + 418] !== 12'hF00) begin n_bad++; $display("FAIL single_inside: got %h want F00", seen[141 * 1024 + 418]); end
    n_cmp++; if (seen[479 * 1024 + 80] !== 12'h00F) begin n_bad++; $display("FAIL overwritten_point: got %h want 00F", seen[479 * 1024 + 80]); end
    n_cmp++; if (seen[80] !== 12'hF00) begin n_bad++; $display("FAIL top_left_marker: got %h want F00", seen[80]); end
    while (expq.size() > 0) begin
      w_e = expq.pop_front(); w_o = obsq.pop_front(); n_cmp++;
      if (w_o !== w_e) begin n_bad++; $display("FAIL stream_five: rgb/hs/vs got %h want %h", w_o, w_e); end
    end
  endtask

  task automatic test_pixen_gap();
    logic [13:0] w_e, w_o;
    gap = 3;
    for (int i = 0; i < 4; i++) put_pt($urandom_range(0, 479), $urandom_range(0, 479));
    longs.push_back(479 - acc[acc.size() - 1].y);
    frame();
    gap = 0;
    n_cmp++; if (frameCount !== 16'(fc_m)) begin n_bad++; $display("FAIL frame_count_gap: got %0d want %0d", frameCount, fc_m); end
    while (expq.size() > 0) begin
      w_e = expq.pop_front(); w_o = obsq.pop_front(); n_cmp++;
      if (w_o !== w_e) begin n_bad++; $display("FAIL stream_gap: rgb/hs/vs got %h want %h", w_o, w_e); end
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] w_e, w_o;
    for (int x = 0; x < 4; x++) pix(1, 1, 1, x, 0);
    while (expq.size() > 0) begin
      w_e = expq.pop_front(); w_o = obsq.pop_front(); n_cmp++;
      if (w_o !== w_e) begin n_bad++; $display("FAIL stream_pre_reset: rgb/hs/vs got %h want %h", w_o, w_e); end
    end
    #2 reset = 0;
    #1;
    n_cmp++; if ({rgb, hsOut, vsOut} !== 14'd0) begin n_bad++; $display("FAIL async_clear: got %h want 0", {rgb, hsOut, vsOut}); end
    n_cmp++; if (frameCount !== 16'd0) begin n_bad++; $display("FAIL async_count: got %0d want 0", frameCount); end
    hw_reset();
    longs = '{$urandom_range(0, 479), 479};
    frame();
    n_cmp++; if (frameCount !== 16'd1) begin n_bad++; $display("FAIL count_after_reset: got %0d want 1", frameCount); end
    while (expq.size() > 0) begin
      w_e = expq.pop_front(); w_o = obsq.pop_front(); n_cmp++;
      if (w_o !== w_e) begin n_bad++; $display("FAIL stream_post_reset: rgb/hs/vs got %h want %h", w_o, w_e); end
    end
  endtask

  task automatic test_random();
    logic [13:0] w_e, w_o;
    int lq[$];
    pend.push_back('{-1, int'($urandom_range(0, 479)), int'($urandom_range(0, 479))});
    for (int i = 0; i < 5; i++)
      pend.push_back('{int'($urandom_range(0, 479)), int'($urandom_range(0, 511)), int'($urandom_range(0, 511))});
    foreach (pend[i]) if (pend[i].y < 480 && lq.size() < 3) lq.push_back(479 - pend[i].y);
    lq.push_back($urandom_range(0, 479));
    longs = lq;
    frame();
    longs = lq;
    frame();
    n_cmp++; if (frameCount !== 16'(fc_m)) begin n_bad++; $display("FAIL frame_count_random: got %0d want %0d", frameCount, fc_m); end
    while (expq.size() > 0) begin
      w_e = expq.pop_front(); w_o = obsq.pop_front(); n_cmp++;
      if (w_o !== w_e) begin n_bad++; $display("FAIL stream_random: rgb/hs/vs got %h want %h", w_o, w_e); end
    end
  endtask

  initial begin
    test_reset();
    test_plain_frame();
    test_point_next_frame();
    test_corner_and_drop();
    test_five_points();
    test_pixen_gap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
